// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
//
// Contents:
//   skid_state_t       : occupancy state of the skid stage (EMPTY / ONE / TWO)
//   PIPE_DEFAULT_WIDTH : default payload width for pipeline registers
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } skid_state_t;

  localparam int PIPE_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register with load enable, synchronous clear and
// asynchronous active-low reset. Clear has priority over load.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset (q -> 0)
//   clr   : synchronous clear (q -> 0), overrides en
//   en    : load d into q
//   d     : next payload
//   q     : registered payload
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register stage with a 2-entry skid buffer.
//
// The main register holds the head entry and drives out_data directly; the
// skid register catches the one beat that can arrive in the cycle after the
// downstream stalls. Because in_ready is decoded from the state register
// alone, there is no combinational path from out_ready to in_ready.
// softReset flushes both entries and discards any beat accepted in the same
// cycle.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high. in_ready and out_valid depend only on registered state. out_data is
// stable while out_valid & !out_ready. Upstream may withdraw in_valid at any
// time without a transfer.
//
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   softReset   : synchronous active-high flush
//   in_valid    : upstream beat present
//   in_data     : upstream payload
//   in_ready    : stage can accept a beat this cycle
//   out_valid   : out_data holds a valid beat
//   out_data    : head-entry payload
//   out_ready   : downstream accepts
//   stall_count : saturating count of upstream-stalled cycles
//                 (only with PIPE_SKID_STALL_CNT_EN defined)
//   state_dbg   : current FSM state, for observation
//
// Build option: define PIPE_SKID_STALL_CNT_EN to add the stall counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH       = PIPE_DEFAULT_WIDTH,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   softReset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
`ifdef PIPE_SKID_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_count,
`endif
  output skid_state_t            state_dbg
);

  if (WIDTH < 1 || WIDTH > 256 || STALL_CNT_W < 1) begin : g_bad_param
    $error("pipe_skid_stage: illegal WIDTH or STALL_CNT_W");
  end

  skid_state_t      state_q, state_d;
  logic             in_fire, out_fire;
  logic             main_en, main_from_skid, skid_en;
  logic [WIDTH-1:0] main_q, skid_q, main_d;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (softReset) begin
      // Flush: data registers are cleared through their clr input.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_en = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state_d = TWO;
            skid_en = 1'b1;
          end else if (!in_fire && out_fire) begin
            state_d = EMPTY;
          end else if (in_fire && out_fire) begin
            main_en = 1'b1;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_d        = ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .clr   (softReset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr   (softReset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

  assign out_data = main_q;

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  // Saturates at all-ones so a long stall never reads back as a short one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (softReset) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_count = stall_q;
`endif

`ifndef SYNTHESIS
  a_no_in_fire_in_two: assert property (
    @(posedge clk) disable iff (!reset) (state_q == TWO) |-> !in_fire);

  a_legal_state: assert property (
    @(posedge clk) disable iff (!reset) (state_q inside {EMPTY, ONE, TWO}));
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage. The reference model is a bounded FIFO of
// capacity 2 held in exp_q: in_ready is expected whenever it has room,
// out_valid whenever it is non-empty, and out_data must equal its head.
// After reset or flush, with nothing accepted since, out_data must be 0.
//
// Timeline per clock period (10 ns): DUT updates at posedge; model updates
// at posedge+1; new stimulus is applied at posedge+2; the monitor compares
// at negedge.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int W   = 32;
  localparam int SCW = 4;

  logic         clk;
  logic         rst_n;
  logic         soft_reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  skid_state_t  state_dbg;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [SCW-1:0] stall_count;
`endif

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  bit           exp_zero = 1'b1;
  bit           mon_en   = 1'b0;
  bit           pop_req;
  bit           flush_req;

  pipe_skid_stage #(.WIDTH(W), .STALL_CNT_W(SCW)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .softReset   (soft_reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
`ifdef PIPE_SKID_STALL_CNT_EN
    .stall_count (stall_count),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      skid_state_t exp_st;
      exp_st = (exp_q.size() == 0) ? EMPTY : (exp_q.size() == 1) ? ONE : TWO;
      check("in_ready",  W'(in_ready),  W'(exp_q.size() < 2));
      check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
      check("state",     W'(state_dbg), W'(exp_st));
      if (exp_q.size() > 0) begin
        check("out_data", out_data, exp_q[0]);
      end else if (exp_zero) begin
        check("out_data_zero", out_data, '0);
      end
      pop_req   = out_ready && (exp_q.size() > 0) && rst_n;
      flush_req = soft_reset;
      @(posedge clk);
      #1;
      if (!rst_n || flush_req) begin
        exp_q.delete();
        exp_zero = 1'b1;
      end else if (pop_req) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+2; returns at the next posedge+2.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy,
                       input bit flush, output bit fired);
    bit will_fire;
    in_valid   = v;
    in_data    = d;
    out_ready  = ordy;
    soft_reset = flush;
    will_fire  = v && rst_n && (exp_q.size() < 2) && !flush;
    @(posedge clk);
    #1;
    if (will_fire) begin
      exp_q.push_back(d);
      exp_zero = 1'b0;
    end
    #1;
    fired = will_fire;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit f;
    for (int i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0, f);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit f;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    soft_reset = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    @(posedge clk);
    #2 mon_en  = 1'b1;
    @(posedge clk);
    #2 rst_n   = 1'b1;

    // 1: reset then stream
    drive(1'b1, 32'h11, 1'b1, 1'b0, f);
    drive(1'b1, 32'h22, 1'b1, 1'b0, f);
    drive(1'b1, 32'h33, 1'b1, 1'b0, f);
    idle(3, 1'b1);

    // 2: backpressure fill, then drain in order
    drive(1'b1, 32'hA1, 1'b0, 1'b0, f);
    drive(1'b1, 32'hA2, 1'b0, 1'b0, f);
    drive(1'b1, 32'hA3, 1'b0, 1'b0, f);
    drive(1'b1, 32'hA3, 1'b0, 1'b0, f);
    f = 1'b0;
    for (int i = 0; i < 8 && !f; i++) drive(1'b1, 32'hA3, 1'b1, 1'b0, f);
    idle(4, 1'b1);

    // 3: simultaneous fire in ONE
    drive(1'b1, 32'h05, 1'b0, 1'b0, f);
    drive(1'b1, 32'h06, 1'b1, 1'b0, f);
    idle(2, 1'b1);

    // 4: flush from TWO with a beat offered in the same cycle
    drive(1'b1, 32'hB1, 1'b0, 1'b0, f);
    drive(1'b1, 32'hB2, 1'b0, 1'b0, f);
    drive(1'b1, 32'hB3, 1'b0, 1'b1, f);
    idle(3, 1'b1);

    // 5: async reset between edges while in TWO
    drive(1'b1, 32'hC1, 1'b0, 1'b0, f);
    drive(1'b1, 32'hC2, 1'b0, 1'b0, f);
    #1 rst_n = 1'b0;
    #1;
    check("async_out_valid", W'(out_valid), '0);
    check("async_out_data",  out_data,       '0);
    check("async_in_ready",  W'(in_ready),   W'(1));
    exp_q.delete();
    exp_zero = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2, 1'b1);

`ifdef PIPE_SKID_STALL_CNT_EN
    // 6: stall counter saturation and flush clear
    drive(1'b0, '0, 1'b0, 1'b1, f);
    check("stall_after_flush", W'(stall_count), '0);
    drive(1'b1, 32'hD1, 1'b0, 1'b0, f);
    drive(1'b1, 32'hD2, 1'b0, 1'b0, f);
    check("stall_full_start", W'(stall_count), '0);
    for (int i = 0; i < 10; i++) drive(1'b1, 32'hD3, 1'b0, 1'b0, f);
    check("stall_ten", W'(stall_count), W'(10));
    for (int i = 0; i < 10; i++) drive(1'b1, 32'hD3, 1'b0, 1'b0, f);
    check("stall_sat", W'(stall_count), W'(15));
    drive(1'b1, 32'hD3, 1'b0, 1'b1, f);
    check("stall_cleared", W'(stall_count), '0);
    idle(2, 1'b1);
`endif

    // randomized traffic with occasional flushes
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0, f);
    end
    idle(4, 1'b1);

    mon_en = 1'b0;
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Elastic pipeline register stage with a valid/ready handshake on both sides and a 2-entry skid buffer. It sits directly upstream of each enabled register wall in the pipeline. It generates a registered ready so that stalls do not form a long combinational ready chain. It also converts the pipeline flush into a synchronous clear of in-flight data.

Parameters:
WIDTH, 32, payload width in bits (legal range 1..256)
STALL_CNT_W, 16, width of the optional stall counter

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
softReset  input  1  synchronous active-high flush; empties the stage
in_valid  input  1  upstream presents in_data
in_data  input  WIDTH  upstream payload
in_ready  output  1  stage can accept; driven directly from the state register
out_valid  output  1  out_data holds a valid entry
out_data  output  WIDTH  head-entry payload; driven directly from the main register
out_ready  input  1  downstream accepts
stall_count  output  STALL_CNT_W  present only with PIPE_SKID_STALL_CNT_EN

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (head entry, drives out_data) and skid register (second entry).
- States:
  - EMPTY: 0 entries.
  - ONE: main register full.
  - TWO: main and skid registers full.
- Output decode: in_ready = (state != TWO); out_valid = (state != EMPTY).
- Transitions, when softReset = 0:
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & !out_fire -> TWO, skid <= in_data.
  - ONE: !in_fire & out_fire -> EMPTY.
  - ONE: in_fire & out_fire -> stay in ONE, main <= in_data.
  - TWO: out_fire -> ONE, main <= skid. in_fire is impossible in TWO.
  - Any other combination: hold state and data.
- Latency: data accepted at edge N is visible on out_data at edge N. First out_valid comes 1 cycle after in_fire. Throughput is 1 beat/cycle when out_ready is held high.
- Order: strict FIFO; no beat is dropped or duplicated except by flush.
- Data registers load only on the transitions listed above; otherwise they hold.
- softReset = 1 overrides all firing:
  - Next state is EMPTY; main and skid clear to 0.
  - An in_fire in the same cycle is discarded. Upstream sees in_ready = 1 for that cycle, and the beat is lost by design because flush kills younger work.
  - An out_fire in the same cycle completes normally downstream.
- Async reset (reset = 0), at any time including mid-transfer:
  - state = EMPTY, main = 0, skid = 0, so in_ready = 1, out_valid = 0, out_data = 0.
  - Deassertion is handled by the existing global synchronizer; no internal synchronizer.
- Downstream protocol: a stable out_data is guaranteed while out_valid & !out_ready.
- Upstream protocol: upstream may drop in_valid without a fire; this is legal.
- Simulation assertions: no transition out of TWO on in_fire; state is never outside the 3 legal encodings.

Optional Feature:
Macro PIPE_SKID_STALL_CNT_EN.
- Defined:
  - Adds the stall_count port.
  - Counts cycles with in_valid & !in_ready, saturating at all-ones (no wrap).
  - Cleared by reset and by softReset.
- Undefined:
  - Port and counter logic are absent.
  - Remaining behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b10}.
  - Constant PIPE_DEFAULT_WIDTH = 32.
- Sub-module pipe_data_reg:
  - WIDTH-bit register with enable, synchronous clear and async active-low reset.
  - Instantiated twice (main, skid).
- FSM and handshake logic stay in the top module.

Test Plan:
1. Reset then stream:
   - Stimulus: reset = 0 for 2 cycles, release; send 0x11, 0x22, 0x33 on consecutive cycles with out_ready = 1.
   - Response: out_valid first rises 1 cycle after the 0x11 fire; outputs are 0x11, 0x22, 0x33 back-to-back; in_ready stays 1.
2. Backpressure fill:
   - Stimulus: out_ready = 0; offer 0xA1, 0xA2, 0xA3.
   - Response: 0xA1 and 0xA2 accepted; in_ready = 0 after the second fire; 0xA3 is held upstream; out_data stays 0xA1.
   - Then raise out_ready: outputs are 0xA1, 0xA2, 0xA3 in order with no loss.
3. Simultaneous fire in ONE:
   - Stimulus: main holds 0x05; in_data = 0x06 with in_valid = 1 and out_ready = 1.
   - Response: next state is ONE and out_data = 0x06.
4. Flush:
   - Stimulus: state TWO (0xB1, 0xB2); pulse softReset with in_valid = 1 and in_data = 0xB3.
   - Response: next cycle out_valid = 0, in_ready = 1, out_data = 0; 0xB3 never appears.
5. Async reset mid-transfer:
   - Stimulus: assert reset low between clock edges while in TWO.
   - Response: out_valid = 0 and out_data = 0 immediately, with no clock edge required.
6. With PIPE_SKID_STALL_CNT_EN and STALL_CNT_W = 4:
   - Stimulus: hold the stage full, in_valid = 1, for 20 cycles.
   - Response: stall_count saturates at 0xF; softReset returns it to 0.
